time_display_scan: RTL and testbench

- Consumes the packed binary time word produced by the timer/clock counters: hours [23:16], minutes [15:8], seconds [7:0].
- Drives a 6-digit multiplexed 7-segment display showing HH.MM.SS.
- Latches new time values only at frame boundaries, so a displayed frame never mixes two time values.
- Blinks selected fields for setup mode and shows dashes for out-of-range fields.

---
 rtl/time_display_scan.sv | 161 ++++++++++++++++
 tb/tb_time_display_scan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/time_display_scan.sv
// rtl/time_display_scan.sv - 6-digit multiplexed HH.MM.SS 7-segment scanner (option: LEADING_ZERO_BLANK_EN)
module time_display_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] data_t,
    input  logic        data_valid,
    input  logic [2:0]  blink_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  dig_sel,
    output logic        frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    logic [PW-1:0] r_prescale;
    logic [2:0]    r_index;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [23:0]   r_staging;
    logic [23:0]   r_shadow;
    logic          r_pending;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [5:0]    r_dig_sel;
    logic          r_frame_done;

    logic          w_tick;
    logic          w_boundary;
    logic          w_blink_wrap;
    logic [7:0]    w_val;
    logic [7:0]    w_lim;
    logic          w_blink_en;
    logic [7:0]    w_bcd;
    logic [3:0]    w_digit;
    logic [6:0]    w_glyph;
    logic          w_dp;
    logic          w_blank;

    // Field values never exceed 59 when decoded, so five subtract steps suffice.
    function automatic logic [7:0] split_bcd(input logic [7:0] v);
        logic [7:0] rem;
        logic [3:0] tens;
        rem  = v;
        tens = 4'd0;
        for (int k = 0; k < 5; k++) begin
            if (rem >= 8'd10) begin
                rem  = rem - 8'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, 4'(rem)};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return GLYPH_DASH;
        endcase
    endfunction

    assign w_tick       = (r_prescale == PW'(SCAN_DIV - 1));
    assign w_boundary   = w_tick && (r_index == 3'd5);
    assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_DIV - 1));

    always_comb begin
        w_val      = r_shadow[7:0];
        w_lim      = 8'd59;
        w_blink_en = blink_mask[0];
        case (r_index[2:1])
            2'd0: begin
                w_val      = r_shadow[7:0];
                w_lim      = 8'd59;
                w_blink_en = blink_mask[0];
            end
            2'd1: begin
                w_val      = r_shadow[15:8];
                w_lim      = 8'd59;
                w_blink_en = blink_mask[1];
            end
            default: begin
                w_val      = r_shadow[23:16];
                w_lim      = 8'd23;
                w_blink_en = blink_mask[2];
            end
        endcase

        w_bcd   = split_bcd(w_val);
        w_digit = r_index[0] ? w_bcd[7:4] : w_bcd[3:0];
        w_glyph = (w_val > w_lim) ? GLYPH_DASH : glyph(w_digit);
`ifdef LEADING_ZERO_BLANK_EN
        if ((r_index == 3'd5) && (w_val <= w_lim) && (w_bcd[7:4] == 4'd0)) begin
            w_glyph = GLYPH_BLANK;
        end
`endif
        w_dp    = !((r_index == 3'd2) || (r_index == 3'd4));
        w_blank = r_blink_phase && w_blink_en;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prescale    <= '0;
            r_index       <= 3'd0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_staging     <= 24'd0;
            r_shadow      <= 24'd0;
            r_pending     <= 1'b0;
            r_seg         <= GLYPH_BLANK;
            r_dp          <= 1'b1;
            r_dig_sel     <= 6'h3F;
            r_frame_done  <= 1'b0;
        end else begin
            r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
            if (w_tick) begin
                r_index <= (r_index == 3'd5) ? 3'd0 : r_index + 3'd1;
            end

            r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
            if (w_blink_wrap) begin
                r_blink_phase <= ~r_blink_phase;
            end

            if (data_valid) begin
                r_staging <= data_t;
                r_pending <= 1'b1;
            end
            // Shadow only moves at the frame boundary; same-cycle data bypasses staging.
            if (w_boundary && (r_pending || data_valid)) begin
                r_shadow  <= data_valid ? data_t : r_staging;
                r_pending <= 1'b0;
            end
            r_frame_done <= w_boundary;

            r_seg     <= w_blank ? GLYPH_BLANK : w_glyph;
            r_dp      <= w_blank ? 1'b1 : w_dp;
            r_dig_sel <= ~(6'b1 << r_index);
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign dig_sel    = r_dig_sel;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_time_display_scan.sv
// tb/tb_time_display_scan.sv - randomized reference-model bench for time_display_scan
module tb_time_display_scan;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 64;
    localparam int FRAME     = SCAN_DIV * 6;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] data_t = 24'd0;
    logic        data_valid = 1'b0;
    logic [2:0]  blink_mask = 3'd0;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  dig_sel;
    logic        frame_done;

    time_display_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_t     (data_t),
        .data_valid (data_valid),
        .blink_mask (blink_mask),
        .seg        (seg),
        .dp         (dp),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [23:0] m_staging = 24'd0;
    logic [23:0] m_shadow  = 24'd0;
    logic        m_pending = 1'b0;
    logic [6:0]  glyphs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_seg_dp(input int idx, input logic [23:0] sh,
                                              input int ph, input logic [2:0] mask);
        int         field;
        int         v;
        int         lim;
        int         d;
        logic [6:0] s;
        logic       p;
        field = idx / 2;
        v     = int'(sh[8*field +: 8]);
        lim   = (field == 2) ? 23 : 59;
        d     = (idx % 2 == 1) ? v / 10 : v % 10;
        s     = (v > lim) ? 7'h3F : glyphs[d];
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 5 && v <= lim && v / 10 == 0) s = 7'h7F;
`endif
        p = (idx == 2 || idx == 4) ? 1'b0 : 1'b1;
        if (ph == 1 && mask[field]) begin
            s = 7'h7F;
            p = 1'b1;
        end
        return {s, p};
    endfunction

    // One clock: drive inputs, predict the outputs after the edge, advance the model, compare.
    task automatic step(input logic rst, input logic dv, input logic [23:0] d, input logic [2:0] mask);
        logic [6:0] e_seg;
        logic       e_dp;
        logic [5:0] e_sel;
        logic       e_fd;
        int         c;
        int         idx;
        logic       bnd;
        reset      = rst;
        data_valid = dv;
        data_t     = d;
        blink_mask = mask;
        if (!rst) begin
            c = 0;
            e_seg = 7'h7F; e_dp = 1'b1; e_sel = 6'h3F; e_fd = 1'b0;
            m_staging = 24'd0; m_shadow = 24'd0; m_pending = 1'b0;
        end else begin
            c   = cyc + 1;
            idx = ((c - 1) / SCAN_DIV) % 6;
            {e_seg, e_dp} = exp_seg_dp(idx, m_shadow, ((c - 1) / BLINK_DIV) % 2, mask);
            e_sel = ~(6'd1 << idx);
            bnd   = (c % FRAME == 0);
            e_fd  = bnd;
            if (bnd && (m_pending || dv)) begin
                m_shadow  = dv ? d : m_staging;
            end
            if (dv) m_staging = d;
            m_pending = bnd ? 1'b0 : (m_pending || dv);
        end
        @(posedge clock);
        #1;
        cyc = c;
        check_eq("seg",        32'(seg),        32'(e_seg));
        check_eq("dp",         32'(dp),         32'(e_dp));
        check_eq("dig_sel",    32'(dig_sel),    32'(e_sel));
        check_eq("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic run(input int n, input logic [2:0] mask);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 24'($urandom), mask);
    endtask

    task automatic run_until_phase(input int ph, input logic [2:0] mask);
        for (int i = 0; i < FRAME && (cyc % FRAME) != ph; i++) step(1'b1, 1'b0, 24'($urandom), mask);
    endtask

    function automatic logic [7:0] rand_field(input int lim);
        if ($urandom_range(0, 7) == 0) return 8'($urandom);
        return 8'($urandom_range(0, lim + 3));
    endfunction

    initial begin
        logic [2:0] mask;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 24'd0, 3'd0);

        step(1'b1, 1'b1, 24'h173B2A, 3'd0);
        run(2 * FRAME, 3'd0);

        run_until_phase(10, 3'd0);
        step(1'b1, 1'b1, 24'h000001, 3'd0);
        run_until_phase(FRAME - 1, 3'd0);
        step(1'b1, 1'b1, 24'h000002, 3'd0);
        run(FRAME + 6, 3'd0);

        step(1'b1, 1'b1, 24'h183C05, 3'd0);
        run(2 * FRAME, 3'd0);

        step(1'b1, 1'b1, 24'h131F2D, 3'b010);
        run(200, 3'b010);

        step(1'b1, 1'b1, 24'h051E07, 3'd0);
        run(2 * FRAME, 3'd0);

        run_until_phase(4, 3'd0);
        step(1'b1, 1'b1, 24'h123456, 3'd0);
        run_until_phase(12, 3'd0);
        step(1'b0, 1'b0, 24'h0, 3'd0);
        step(1'b0, 1'b0, 24'h0, 3'd0);
        run(2 * FRAME + 4, 3'd0);

        mask = 3'd0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 97 == 0) mask = 3'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                step(1'b0, 1'b0, 24'($urandom), mask);
            end else if ($urandom_range(0, 7) == 0) begin
                step(1'b1, 1'b1, {rand_field(23), rand_field(59), rand_field(59)}, mask);
            end else begin
                step(1'b1, 1'b0, 24'($urandom), mask);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
